s4_shift_sequencer: RTL and testbench

Upstream control stage for the 4-bit universal shift register. It accepts parallel words over a valid/ready handshake and drives that register's sel, inp1, sr_ser and sl_ser inputs: one load, then WIDTH shifts, then hold. It reads the register's parallel output back and presents the serial bit stream, LSB-first or MSB-first, with a per-bit strobe and an end-of-word pulse.

---
 rtl/s4_shift_sequencer_if.sv | 38 +++
 rtl/s4_shift_sequencer.sv | 154 +++++++++++++++
 tb/tb_s4_shift_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/s4_shift_sequencer_if.sv
// rtl/s4_shift_sequencer_if.sv - upstream word handshake for the shift sequencer
//
// Purpose: bundles the valid/ready word offer that feeds s4_shift_sequencer.
// Signals:
//   in_valid  word offered by upstream
//   in_ready  sequencer can accept a word
//   in_data   parallel word to serialize
//   in_dir    0 = shift right / LSB first, 1 = shift left / MSB first
//   in_fill   bit shifted into the vacated end during shifts
// Modports: master = word producer, slave = sequencer.

interface s4_shift_sequencer_if #(
  parameter int WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic             in_fill;

  modport master (
    output in_valid,
    output in_data,
    output in_dir,
    output in_fill,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dir,
    input  in_fill,
    output in_ready
  );

endinterface

// File: rtl/s4_shift_sequencer.sv
// rtl/s4_shift_sequencer.sv - load/shift/hold control stage for a universal shift register
//
// Purpose: accepts one parallel word over the upstream handshake, loads it
// into an external universal shift register, shifts it out WIDTH times in the
// captured direction and reports each bit plus an end-of-word pulse.
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset, shared with the shift register
//   up         upstream word handshake (slave side)
//   reg_q      shift register parallel output fed back for bit extraction
//   sel        register mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   inp1       register parallel-load data
//   sr_ser     register right-shift serial input
//   sl_ser     register left-shift serial input
//   bit_out    current serial bit (qualify with bit_valid)
//   bit_valid  bit_out carries a word bit this cycle
//   done       one-cycle end-of-word pulse
//   busy       sequencer is not idle

module s4_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  s4_shift_sequencer_if.slave up,
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] inp1,
  output logic             sr_ser,
  output logic             sl_ser,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             dir_q,   dir_d;
  logic             fill_q,  fill_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state logic. The captured word, direction and fill only change on
  // acceptance in IDLE, so upstream may change its inputs freely afterwards.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dir_d   = dir_q;
    fill_d  = fill_q;

    unique case (state_q)
      ST_IDLE: begin
        if (up.in_valid) begin
          data_d  = up.in_data;
          dir_d   = up.in_dir;
          fill_d  = up.in_fill;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The counter parks at WIDTH-1 on the last shift; it only returns to
        // zero through LOAD.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode, purely from registered state.
  always_comb begin
    sel         = SEL_HOLD;
    inp1        = '0;
    sr_ser      = 1'b0;
    sl_ser      = 1'b0;
    bit_valid   = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    up.in_ready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy        = 1'b0;
        up.in_ready = 1'b1;
      end
      ST_LOAD: begin
        sel  = SEL_LOAD;
        inp1 = data_q;
      end
      ST_SHIFT: begin
        sel       = dir_q ? SEL_LEFT : SEL_RIGHT;
        sr_ser    = dir_q ? 1'b0 : fill_q;
        sl_ser    = dir_q ? fill_q : 1'b0;
        bit_valid = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // The outgoing bit is the end of the register that is about to fall off;
  // consumers sample it at the closing edge, before the shift lands.
  assign bit_out = dir_q ? reg_q[WIDTH-1] : reg_q[0];

endmodule

// File: tb/tb_s4_shift_sequencer.sv
// tb/tb_s4_shift_sequencer.sv - self-checking bench for s4_shift_sequencer

module tb_s4_shift_sequencer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  s4_shift_sequencer_if #(.WIDTH(W)) up ();

  logic [W-1:0] reg_q;
  logic [W-1:0] inp1;
  logic [1:0]   sel;
  logic         sr_ser, sl_ser, bit_out, bit_valid, done, busy;

  s4_shift_sequencer #(.WIDTH(W), .CNT_W(3)) dut (
    .clk       (clk),
    .clr       (clr),
    .up        (up),
    .reg_q     (reg_q),
    .sel       (sel),
    .inp1      (inp1),
    .sr_ser    (sr_ser),
    .sl_ser    (sl_ser),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .done      (done),
    .busy      (busy)
  );

  // Universal shift register driven by the sequencer.
  always @(posedge clk or negedge clr) begin
    if (!clr) reg_q <= '0;
    else begin
      case (sel)
        2'b01:   reg_q <= {sr_ser, reg_q[W-1:1]};
        2'b10:   reg_q <= {reg_q[W-2:0], sl_ser};
        2'b11:   reg_q <= inp1;
        default: reg_q <= reg_q;
      endcase
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: a word accepted at edge acc_n occupies cycle offsets
  // 0 (load), 1..W (bits), W+1 (done); offsets >= W+2 are idle again.
  int           n = 0;
  bit           active = 0;
  int           acc_n = 0;
  logic [W-1:0] m_data = '0;
  logic         m_dir = 1'b0;
  logic         m_fill = 1'b0;
  logic [W-1:0] last_reg = '0;
  bit           just_acc = 0;

  int dut_acc_q[$];
  int done_q[$];
  bit obs_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [W-1:0] exp_reg(input int shifts);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int src;
      src = m_dir ? i - shifts : i + shifts;
      r[i] = (src >= 0 && src < W) ? m_data[src] : m_fill;
    end
    return r;
  endfunction

  function automatic logic [31:0] pack_obs();
    logic [31:0] v;
    v = '0;
    foreach (obs_q[i]) v = (v << 1) | 32'(obs_q[i]);
    return v;
  endfunction

  task automatic check_cycle();
    int t;
    if (!clr) return;
    if (up.in_valid && up.in_ready) dut_acc_q.push_back(n);
    if (done) done_q.push_back(n);
    if (bit_valid) obs_q.push_back(bit_out);
    t = n - acc_n;
    if (!active || t >= W + 2) begin
      check("idle_sel",   32'(sel),         32'd0);
      check("idle_bv",    32'(bit_valid),   32'd0);
      check("idle_done",  32'(done),        32'd0);
      check("idle_busy",  32'(busy),        32'd0);
      check("idle_ready", 32'(up.in_ready), 32'd1);
      check("idle_reg",   32'(reg_q),       32'(last_reg));
    end else if (t == 0) begin
      check("load_sel",   32'(sel),         32'd3);
      check("load_inp1",  32'(inp1),        32'(m_data));
      check("load_ready", 32'(up.in_ready), 32'd0);
      check("load_busy",  32'(busy),        32'd1);
      check("load_bv",    32'(bit_valid),   32'd0);
    end else if (t <= W) begin
      check("shift_sel",  32'(sel),         m_dir ? 32'd2 : 32'd1);
      check("shift_sr",   32'(sr_ser),      m_dir ? 32'd0 : 32'(m_fill));
      check("shift_sl",   32'(sl_ser),      m_dir ? 32'(m_fill) : 32'd0);
      check("shift_bv",   32'(bit_valid),   32'd1);
      check("shift_bit",  32'(bit_out),     32'(m_dir ? m_data[W - t] : m_data[t - 1]));
      check("shift_reg",  32'(reg_q),       32'(exp_reg(t - 1)));
      check("shift_done", 32'(done),        32'd0);
      check("shift_ready",32'(up.in_ready), 32'd0);
    end else begin
      check("done_sel",   32'(sel),         32'd0);
      check("done_pulse", 32'(done),        32'd1);
      check("done_bv",    32'(bit_valid),   32'd0);
      check("done_ready", 32'(up.in_ready), 32'd0);
      check("done_busy",  32'(busy),        32'd1);
      check("done_reg",   32'(reg_q),       32'({W{m_fill}}));
    end
  endtask

  task automatic tick();
    bit           acc;
    logic [W-1:0] d;
    logic         dr, f;
    check_cycle();
    acc = clr && up.in_valid && (!active || (n - acc_n) >= W + 2);
    d = up.in_data; dr = up.in_dir; f = up.in_fill;
    @(posedge clk);
    n++;
    just_acc = acc;
    if (acc) begin
      active   = 1;
      acc_n    = n;
      m_data   = d;
      m_dir    = dr;
      m_fill   = f;
      last_reg = {W{f}};
    end
    #1;
  endtask

  task automatic idle_ticks(input int m);
    for (int i = 0; i < m; i++) tick();
  endtask

  task automatic offer(input logic [W-1:0] d, input logic dr, input logic f);
    up.in_valid = 1'b1;
    up.in_data  = d;
    up.in_dir   = dr;
    up.in_fill  = f;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (just_acc) break;
    end
    if (!just_acc) check("accept_timeout", 32'd0, 32'd1);
    up.in_valid = 1'b0;
    up.in_data  = W'($urandom);
    up.in_dir   = 1'($urandom);
    up.in_fill  = 1'($urandom);
  endtask

  task automatic reset_now();
    clr = 1'b0;
    #1;
    check("rst_sel",  32'(sel),       32'd0);
    check("rst_bv",   32'(bit_valid), 32'd0);
    check("rst_done", 32'(done),      32'd0);
    check("rst_busy", 32'(busy),      32'd0);
    check("rst_reg",  32'(reg_q),     32'd0);
    active   = 0;
    last_reg = '0;
  endtask

  initial begin
    up.in_valid = 1'b0;
    up.in_data  = '0;
    up.in_dir   = 1'b0;
    up.in_fill  = 1'b0;

    // Reset then idle
    idle_ticks(3);
    clr = 1'b1;
    idle_ticks(2);
    check("reset_reg", 32'(reg_q), 32'd0);

    // LSB-first, fill 0
    obs_q.delete(); done_q.delete(); dut_acc_q.delete();
    offer(4'b1011, 1'b0, 1'b0);
    idle_ticks(7);
    check("lsb_stream", pack_obs(), 32'b1101);
    check("lsb_ndone", 32'(done_q.size()), 32'd1);
    if (done_q.size() == 1 && dut_acc_q.size() == 1)
      check("lsb_done_lat", 32'(done_q[0] - dut_acc_q[0]), 32'd6);
    check("lsb_reg_end", 32'(reg_q), 32'b0000);

    // MSB-first, fill 1
    obs_q.delete();
    offer(4'b1011, 1'b1, 1'b1);
    idle_ticks(7);
    check("msb_stream", pack_obs(), 32'b1011);
    check("msb_reg_end", 32'(reg_q), 32'b1111);

    // Busy rejection: second word held valid while the first is in flight
    obs_q.delete(); dut_acc_q.delete();
    offer(4'b1001, 1'b0, 1'b0);
    offer(4'b0110, 1'b0, 1'b0);
    idle_ticks(7);
    check("busy_stream", pack_obs(), 32'b1001_0110);
    check("busy_nacc", 32'(dut_acc_q.size()), 32'd2);
    if (dut_acc_q.size() == 2)
      check("busy_spacing", 32'(dut_acc_q[1] - dut_acc_q[0]), 32'(W + 3));

    // Mid-word reset after the second bit
    obs_q.delete(); done_q.delete();
    offer(4'b1100, 1'b0, 1'b0);
    idle_ticks(3);
    reset_now();
    idle_ticks(2);
    clr = 1'b1;
    tick();
    offer(4'b0011, 1'b0, 1'b0);
    idle_ticks(7);
    check("abort_stream", pack_obs(), 32'b00_1100);
    check("abort_ndone", 32'(done_q.size()), 32'd1);

    // Back-to-back words
    obs_q.delete(); done_q.delete();
    offer(4'b0001, 1'b0, 1'b0);
    offer(4'b1000, 1'b0, 1'b0);
    offer(4'b1111, 1'b0, 1'b0);
    idle_ticks(7);
    check("b2b_stream", pack_obs(), 32'b1000_0001_1111);
    check("b2b_ndone", 32'(done_q.size()), 32'd3);
    if (done_q.size() == 3) begin
      check("b2b_gap1", 32'(done_q[1] - done_q[0]), 32'd7);
      check("b2b_gap2", 32'(done_q[2] - done_q[1]), 32'd7);
    end

    // Randomized words, gaps and occasional aborts
    for (int w = 0; w < 40; w++) begin
      offer(W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(9) == 0) begin
        idle_ticks($urandom_range(6));
        reset_now();
        tick();
        clr = 1'b1;
      end
      idle_ticks($urandom_range(3));
    end
    idle_ticks(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
